// File: rtl/rr_mux_arbiter.sv
// Two-requester round-robin packet arbiter with a combinational output mux.
// Optional forced-release timeout is built only when ARB_TIMEOUT_EN is defined.
module rr_mux_arbiter #(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             A_VALID,
  input  logic [WIDTH-1:0] A_DATA,
  input  logic             A_LAST,
  output logic             A_READY,
  input  logic             B_VALID,
  input  logic [WIDTH-1:0] B_DATA,
  input  logic             B_LAST,
  output logic             B_READY,
  output logic             Y_VALID,
  output logic [WIDTH-1:0] Y_DATA,
  output logic             Y_LAST,
  input  logic             Y_READY,
  output logic             S,
  output logic             BUSY,
  output logic             TOUT
);

  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;
  logic   sel, sel_nxt;
  logic   last_xfer;
  logic   force_rel;

  assign last_xfer = Y_VALID & Y_READY & Y_LAST;

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr   <= 1'b0;
      sel   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
      sel   <= sel_nxt;
    end
  end

  // The grant decision is only taken from IDLE, so a release always costs one idle cycle.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    sel_nxt   = sel;
    case (state)
      IDLE: begin
        if (A_VALID && B_VALID)
          state_nxt = ptr ? GRANT_B : GRANT_A;
        else if (A_VALID)
          state_nxt = GRANT_A;
        else if (B_VALID)
          state_nxt = GRANT_B;
        if (A_VALID || B_VALID)
          sel_nxt = (state_nxt == GRANT_B);
      end
      GRANT_A: begin
        if (last_xfer || force_rel) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b1;
        end
      end
      GRANT_B: begin
        if (last_xfer || force_rel) begin
          state_nxt = IDLE;
          ptr_nxt   = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    S       = sel;
    BUSY    = (state == GRANT_A) || (state == GRANT_B);
    Y_DATA  = sel ? B_DATA : A_DATA;
    Y_LAST  = sel ? B_LAST : A_LAST;
    Y_VALID = 1'b0;
    A_READY = 1'b0;
    B_READY = 1'b0;
    case (state)
      GRANT_A: begin
        Y_VALID = A_VALID;
        A_READY = Y_READY;
      end
      GRANT_B: begin
        Y_VALID = B_VALID;
        B_READY = Y_READY;
      end
      default: ;
    endcase
  end

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt;
  logic             other_valid;

  // Counter is zero on the first grant cycle and saturates, so a release can wait for the other side.
  always_ff @(posedge CLK) begin
    if (RST || state == IDLE)
      cnt <= '0;
    else if (cnt < CNT_W'(TIMEOUT))
      cnt <= cnt + 1'b1;
  end

  always_comb begin
    other_valid = 1'b0;
    if (state == GRANT_A)
      other_valid = B_VALID;
    else if (state == GRANT_B)
      other_valid = A_VALID;
  end

  assign force_rel = other_valid & ~last_xfer & (cnt >= CNT_W'(TIMEOUT - 1));
  assign TOUT      = force_rel & ~RST;
`else
  logic [31:0] unused_timeout;

  assign unused_timeout = 32'(TIMEOUT);
  assign force_rel      = 1'b0;
  assign TOUT           = 1'b0;
`endif

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Directed table-driven bench for rr_mux_arbiter, plus timeout / hold sequences
// selected by ARB_TIMEOUT_EN.
module tb_rr_mux_arbiter;

  logic       CLK = 1'b0;
  logic       RST;
  logic       A_VALID, A_LAST, A_READY;
  logic [7:0] A_DATA;
  logic       B_VALID, B_LAST, B_READY;
  logic [7:0] B_DATA;
  logic       Y_VALID, Y_LAST, Y_READY;
  logic [7:0] Y_DATA;
  logic       S, BUSY, TOUT;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic       rst, av;
    logic [7:0] ad;
    logic       al, bv;
    logic [7:0] bd;
    logic       bl, yr;
    logic       s, busy, yv;
    logic [7:0] yd;
    logic       yl, ar, br;
  } vec_t;

  vec_t tbl[$];

  rr_mux_arbiter #(.WIDTH(8), .TIMEOUT(4)) dut (
    .CLK(CLK), .RST(RST),
    .A_VALID(A_VALID), .A_DATA(A_DATA), .A_LAST(A_LAST), .A_READY(A_READY),
    .B_VALID(B_VALID), .B_DATA(B_DATA), .B_LAST(B_LAST), .B_READY(B_READY),
    .Y_VALID(Y_VALID), .Y_DATA(Y_DATA), .Y_LAST(Y_LAST), .Y_READY(Y_READY),
    .S(S), .BUSY(BUSY), .TOUT(TOUT)
  );

  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst, av, input logic [7:0] ad, input logic al, bv,
                     input logic [7:0] bd, input logic bl, yr, s, busy, yv,
                     input logic [7:0] yd, input logic yl, ar, br);
    vec_t v;
    v.rst = rst; v.av = av; v.ad = ad; v.al = al; v.bv = bv; v.bd = bd; v.bl = bl; v.yr = yr;
    v.s = s; v.busy = busy; v.yv = yv; v.yd = yd; v.yl = yl; v.ar = ar; v.br = br;
    tbl.push_back(v);
  endtask

  // Inputs change on the falling edge; outputs are sampled 1 time unit later.
  task automatic drive(input logic rst, av, input logic [7:0] ad, input logic al, bv,
                       input logic [7:0] bd, input logic bl, yr);
    @(negedge CLK);
    RST = rst; A_VALID = av; A_DATA = ad; A_LAST = al;
    B_VALID = bv; B_DATA = bd; B_LAST = bl; Y_READY = yr;
    #1;
  endtask

  initial begin
    RST = 1'b1; A_VALID = 1'b1; A_DATA = 8'h11; A_LAST = 1'b0;
    B_VALID = 1'b1; B_DATA = 8'hAA; B_LAST = 1'b0; Y_READY = 1'b1;

    // reset with both requesters valid, then contention: A wins with PTR=0
    add(1,1,8'h11,0,1,8'hAA,0,1, 0,0,0,8'h11,0,0,0);
    add(1,1,8'h11,0,1,8'hAA,0,1, 0,0,0,8'h11,0,0,0);
    add(0,1,8'h11,0,1,8'hAA,0,1, 0,0,0,8'h11,0,0,0);
    add(0,1,8'h11,0,1,8'hAA,0,1, 0,1,1,8'h11,0,1,0);
    add(0,1,8'h22,0,1,8'hAA,0,1, 0,1,1,8'h22,0,1,0);
    add(0,1,8'h33,1,1,8'hAA,0,1, 0,1,1,8'h33,1,1,0);
    add(0,1,8'h44,0,1,8'hAA,0,1, 0,0,0,8'h44,0,0,0);
    // B granted, backpressure for four cycles
    add(0,0,8'h45,0,1,8'hAA,0,0, 1,1,1,8'hAA,0,0,0);
    add(0,0,8'h46,0,1,8'hAA,0,0, 1,1,1,8'hAA,0,0,0);
    add(0,0,8'h47,0,1,8'hAA,0,0, 1,1,1,8'hAA,0,0,0);
    add(0,0,8'h48,0,1,8'hAA,0,0, 1,1,1,8'hAA,0,0,0);
    add(0,0,8'h49,0,1,8'hAA,0,1, 1,1,1,8'hAA,0,0,1);
    add(0,0,8'h4A,0,1,8'hBB,1,1, 1,1,1,8'hBB,1,0,1);
    // idle mux follows S=1
    add(0,0,8'h55,1,0,8'hCC,0,1, 1,0,0,8'hCC,0,0,0);
    // single requester A, two one-beat packets
    add(0,1,8'h61,1,0,8'hCC,0,1, 1,0,0,8'hCC,0,0,0);
    add(0,1,8'h61,1,0,8'hCC,0,1, 0,1,1,8'h61,1,1,0);
    add(0,1,8'h62,1,0,8'hCC,0,1, 0,0,0,8'h62,1,0,0);
    add(0,1,8'h62,1,0,8'hCC,0,1, 0,1,1,8'h62,1,1,0);
    // A drops VALID mid-grant; grant holds, B cannot steal
    add(0,1,8'h71,0,0,8'h00,0,1, 0,0,0,8'h71,0,0,0);
    add(0,1,8'h71,0,0,8'h00,0,1, 0,1,1,8'h71,0,1,0);
    add(0,0,8'h72,0,1,8'hD1,0,1, 0,1,0,8'h72,0,1,0);
    add(0,1,8'h73,1,0,8'hD1,0,1, 0,1,1,8'h73,1,1,0);
    // reset during beat 2 with PTR=1; afterwards A must win contention
    add(0,1,8'h81,0,0,8'h00,0,1, 0,0,0,8'h81,0,0,0);
    add(0,1,8'h81,0,0,8'h00,0,1, 0,1,1,8'h81,0,1,0);
    add(1,1,8'h82,0,1,8'hE0,0,1, 0,1,1,8'h82,0,1,0);
    add(0,1,8'h83,0,1,8'hE0,0,1, 0,0,0,8'h83,0,0,0);
    add(0,1,8'h84,1,1,8'hE0,0,1, 0,1,1,8'h84,1,1,0);
    add(0,1,8'h85,0,1,8'hE0,0,1, 0,0,0,8'h85,0,0,0);
    add(0,0,8'h86,0,1,8'hE1,1,1, 1,1,1,8'hE1,1,0,1);

    @(posedge CLK);
    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].av, tbl[i].ad, tbl[i].al, tbl[i].bv, tbl[i].bd, tbl[i].bl, tbl[i].yr);
      chk($sformatf("row%0d_s", i),       8'(S),       8'(tbl[i].s));
      chk($sformatf("row%0d_busy", i),    8'(BUSY),    8'(tbl[i].busy));
      chk($sformatf("row%0d_y_valid", i), 8'(Y_VALID), 8'(tbl[i].yv));
      chk($sformatf("row%0d_y_data", i),  Y_DATA,      tbl[i].yd);
      chk($sformatf("row%0d_y_last", i),  8'(Y_LAST),  8'(tbl[i].yl));
      chk($sformatf("row%0d_a_ready", i), 8'(A_READY), 8'(tbl[i].ar));
      chk($sformatf("row%0d_b_ready", i), 8'(B_READY), 8'(tbl[i].br));
      chk($sformatf("row%0d_tout", i),    8'(TOUT),    8'h00);
    end

`ifdef ARB_TIMEOUT_EN
    // A never sends LAST while B waits: forced release on the 4th grant cycle
    drive(0,1,8'h90,0,1,8'hF0,0,1);
    chk("to_idle_busy", 8'(BUSY), 8'h00);
    for (int i = 1; i <= 4; i++) begin
      drive(0,1,8'h90,0,1,8'hF0,0,1);
      chk($sformatf("to_g%0d_busy", i), 8'(BUSY), 8'h01);
      chk($sformatf("to_g%0d_s", i),    8'(S),    8'h00);
      chk($sformatf("to_g%0d_tout", i), 8'(TOUT), (i == 4) ? 8'h01 : 8'h00);
    end
    drive(0,1,8'h90,0,1,8'hF0,0,1);
    chk("to_rel_busy", 8'(BUSY), 8'h00);
    chk("to_rel_tout", 8'(TOUT), 8'h00);
    drive(0,1,8'h90,0,1,8'hF0,0,1);
    chk("to_gb_s",    8'(S),    8'h01);
    chk("to_gb_busy", 8'(BUSY), 8'h01);
    chk("to_gb_data", Y_DATA,   8'hF0);
    // A idle: counter saturates, release waits for A_VALID
    for (int i = 0; i < 6; i++) begin
      drive(0,0,8'h91,0,1,8'hF0,0,1);
      chk($sformatf("sat%0d_busy", i), 8'(BUSY), 8'h01);
      chk($sformatf("sat%0d_tout", i), 8'(TOUT), 8'h00);
    end
    drive(0,1,8'h92,0,1,8'hF0,0,1);
    chk("sat_rel_tout", 8'(TOUT), 8'h01);
    drive(0,1,8'h92,0,1,8'hF0,0,1);
    chk("sat_idle_busy", 8'(BUSY), 8'h00);
    drive(0,1,8'h92,0,1,8'hF0,0,1);
    chk("sat_ga_s",    8'(S),    8'h00);
    chk("sat_ga_busy", 8'(BUSY), 8'h01);
`else
    // without the timeout, A holds the grant indefinitely despite B waiting
    drive(0,1,8'h90,0,1,8'hF0,0,1);
    chk("hold_idle_busy", 8'(BUSY), 8'h00);
    for (int i = 0; i < 10; i++) begin
      drive(0,1,8'h90,0,1,8'hF0,0,1);
      chk($sformatf("hold%0d_busy", i), 8'(BUSY),  8'h01);
      chk($sformatf("hold%0d_s", i),    8'(S),     8'h00);
      chk($sformatf("hold%0d_data", i), Y_DATA,    8'h90);
      chk($sformatf("hold%0d_tout", i), 8'(TOUT),  8'h00);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
